// File: rtl/aes_inv_if.sv
// Handshake and data bundle shared by the AES inverse cipher and its driver.
interface aes_inv_if #(parameter int KEY_SIZE = 128);
  logic                en;
  logic [127:0]        state;
  logic [KEY_SIZE-1:0] key;
  logic                done;
  logic [127:0]        state_out;

  modport master (output en, state, key, input done, state_out);
  modport slave  (input en, state, key, output done, state_out);
endinterface

// File: rtl/aes_inv.sv
// Iterative AES inverse cipher: expands the key schedule one word per cycle
// into a local store, then runs one inverse round per cycle from rk[Nr] down.
module aes_inv #(
  parameter int KEY_SIZE = 128
) (
  input  logic      clk,
  input  logic      rst,
  aes_inv_if.slave  bus
);
  if (KEY_SIZE != 128 && KEY_SIZE != 192 && KEY_SIZE != 256) begin : g_bad_key_size
    $fatal(1, "aes_inv: KEY_SIZE must be 128, 192 or 256");
  end

  localparam int NK = KEY_SIZE / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);
  localparam logic [5:0] NK_W    = 6'(NK);
  localparam logic [5:0] NW_LAST = 6'(NW - 1);
  localparam logic [2:0] NK_LAST = 3'(NK - 1);
  localparam logic [3:0] NR_R    = 4'(NR);

  localparam logic [2:0] S_IDLE = 3'd0, S_KEYEXP = 3'd1, S_INIT = 3'd2,
                         S_ROUND = 3'd3, S_DONE = 3'd4;

  localparam logic [2047:0] FWD_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  // Table entry 0 sits in the most significant byte of each table.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return FWD_SBOX[{8'hff - x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX[{8'hff - x, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Column bytes are little-endian: row j lives in bits [8j+:8].
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [31:0] res;
    for (int j = 0; j < 4; j++) begin
      a[j]  = col[8*j +: 8];
      x2[j] = xtime(a[j]);
      x4[j] = xtime(x2[j]);
      x8[j] = xtime(x4[j]);
    end
    for (int j = 0; j < 4; j++) begin
      res[8*j +: 8] = (x8[j] ^ x4[j] ^ x2[j])                         // 0e
                    ^ (x8[(j+1)%4] ^ x2[(j+1)%4] ^ a[(j+1)%4])         // 0b
                    ^ (x8[(j+2)%4] ^ x4[(j+2)%4] ^ a[(j+2)%4])         // 0d
                    ^ (x8[(j+3)%4] ^ a[(j+3)%4]);                      // 09
    end
    return res;
  endfunction

  logic [2:0]   fsm_r;
  logic [127:0] s_r;
  logic [3:0]   rnd_r;
  logic [5:0]   widx_r;
  logic [2:0]   kcnt_r;
  logic [7:0]   rcon_r;
  logic         done_r;
  logic [127:0] out_r;
  logic [31:0]  w_r [NW];

  logic [31:0]  prev_word_s;
  logic [31:0]  temp_word_s;
  logic [31:0]  new_word_s;
  logic [127:0] rk_s;
  logic [127:0] isr_s;
  logic [127:0] ark_s;
  logic [127:0] imc_s;

  // Next key-schedule word w[widx] from w[widx-1] and w[widx-Nk].
  always_comb begin
    prev_word_s = w_r[widx_r - 6'd1];
    if (kcnt_r == 3'd0) begin
      temp_word_s = sub_word({prev_word_s[7:0], prev_word_s[31:8]}) ^ {24'd0, rcon_r};
    end else if (NK == 8 && kcnt_r == 3'd4) begin
      temp_word_s = sub_word(prev_word_s);
    end else begin
      temp_word_s = prev_word_s;
    end
    new_word_s = w_r[widx_r - NK_W] ^ temp_word_s;
  end

  // Inverse round datapath for the round key selected by the round counter.
  always_comb begin
    rk_s = {w_r[{rnd_r, 2'b11}], w_r[{rnd_r, 2'b10}], w_r[{rnd_r, 2'b01}], w_r[{rnd_r, 2'b00}]};
    isr_s = 128'd0;
    ark_s = 128'd0;
    imc_s = 128'd0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        isr_s[8*(4*c+r) +: 8] = s_r[8*(4*((c+4-r)%4)+r) +: 8];
      end
    end
    for (int k = 0; k < 16; k++) begin
      ark_s[8*k +: 8] = inv_sbox(isr_s[8*k +: 8]) ^ rk_s[8*k +: 8];
    end
    for (int c = 0; c < 4; c++) begin
      imc_s[32*c +: 32] = inv_mix_col(ark_s[32*c +: 32]);
    end
  end

  // Round-key store: cipher key words on start, one expanded word per KEYEXP cycle.
  always_ff @(posedge clk) begin
    if (fsm_r == S_IDLE && bus.en) begin
      for (int j = 0; j < NK; j++) begin
        w_r[j] <= bus.key[32*j +: 32];
      end
    end else if (fsm_r == S_KEYEXP) begin
      w_r[widx_r] <= new_word_s;
    end
  end

  // Control FSM, cipher state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_r  <= S_IDLE;
      s_r    <= 128'd0;
      rnd_r  <= 4'd0;
      widx_r <= 6'd0;
      kcnt_r <= 3'd0;
      rcon_r <= 8'd0;
      done_r <= 1'b0;
      out_r  <= 128'd0;
    end else begin
      case (fsm_r)
        S_IDLE: begin
          if (bus.en) begin
            s_r    <= bus.state;
            widx_r <= NK_W;
            kcnt_r <= 3'd0;
            rcon_r <= 8'h01;
            rnd_r  <= NR_R;
            fsm_r  <= S_KEYEXP;
          end
        end
        S_KEYEXP: begin
          widx_r <= widx_r + 6'd1;
          kcnt_r <= (kcnt_r == NK_LAST) ? 3'd0 : kcnt_r + 3'd1;
          if (kcnt_r == 3'd0) rcon_r <= xtime(rcon_r);
          if (widx_r == NW_LAST) fsm_r <= S_INIT;
        end
        S_INIT: begin
          s_r   <= s_r ^ rk_s;
          rnd_r <= rnd_r - 4'd1;
          fsm_r <= S_ROUND;
        end
        S_ROUND: begin
          if (rnd_r != 4'd0) begin
            s_r   <= imc_s;
            rnd_r <= rnd_r - 4'd1;
          end else begin
            s_r    <= ark_s;
            out_r  <= ark_s;
            done_r <= 1'b1;
            fsm_r  <= S_DONE;
          end
        end
        S_DONE: begin
          if (!bus.en) begin
            done_r <= 1'b0;
            fsm_r  <= S_IDLE;
          end
        end
        default: fsm_r <= S_IDLE;
      endcase
    end
  end

  assign bus.done      = done_r;
  assign bus.state_out = out_r;
endmodule
